// File: rtl/flappy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flappy_pkg
//  Description : Shared constants and types for the flappy game blocks:
//                screen/tube geometry and the tube scheduler state encoding.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package flappy_pkg;

  localparam int SCREEN_W   = 1024;
  localparam int TUBE_WIDTH = 120;
  localparam int GAP_HEIGHT = 250;
  localparam int NUM_TUBES  = 3;
  localparam int BIRD1_X    = 180;

  // Width of a tube coordinate as seen by the renderer
  localparam int X_W = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SWEEP  = 2'd2,
    FROZEN = 2'd3
  } tube_state_t;

endpackage
`default_nettype wire

// File: rtl/tube_ctl_if.sv
`default_nettype none
// ============================================================================
//  Module      : tube_ctl_if
//  Description : Game-side bundle between the tube scheduler and its user.
//  Signals     : frame_tick  - one-cycle frame pulse
//                start       - one-cycle (re)start pulse
//                hold        - level, freezes tube motion
//                tube_x      - 3 x 11-bit tube left edges
//                gap_y       - 3 x 11-bit gap top rows
//                running     - scheduler in RUN or SWEEP
//                pass_pulse  - one-cycle pulse when a tube is cleared
//  Modports    : master (game/controller side), slave (tube_ctl)
//  Revision    : 1.0 - initial release
// ============================================================================
interface tube_ctl_if;
  import flappy_pkg::*;

  logic                          frame_tick;
  logic                          start;
  logic                          hold;
  logic [NUM_TUBES-1:0][X_W-1:0] tube_x;
  logic [NUM_TUBES-1:0][X_W-1:0] gap_y;
  logic                          running;
  logic                          pass_pulse;

  modport master (
    output frame_tick, start, hold,
    input  tube_x, gap_y, running, pass_pulse
  );

  modport slave (
    input  frame_tick, start, hold,
    output tube_x, gap_y, running, pass_pulse
  );

endinterface
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr16
//  Description : Free-running 16-bit Fibonacci LFSR, taps 16/14/13/11,
//                right-shifting. Loads seed while rst is high.
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset
//                seed - reset value (must be non-zero)
//                q    - current LFSR state
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Taps 16/14/13/11 map to bits 0/2/3/5 in the right-shift form
  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/tube_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : tube_ctl
//  Description : Per-frame tube scheduler. On each accepted frame tick the
//                three tubes are swept one per cycle through one shared
//                move/wrap datapath. Tubes leaving the left edge are
//                recycled to the right with a pseudo-random gap, and a
//                pass pulse is raised when a tube's right edge crosses
//                PASS_X. All outputs are registered.
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset
//                bus  - tube_ctl_if.slave (frame_tick, start, hold in;
//                       tube_x, gap_y, running, pass_pulse out)
//  Revision    : 1.0 - initial release
// ============================================================================
module tube_ctl
  import flappy_pkg::*;
#(
  parameter int unsigned SPEED   = 2,
  parameter int unsigned SPACING = 400,
  parameter int unsigned GAP_MIN = 80,
  parameter int unsigned PASS_X  = 180,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  tube_ctl_if.slave  bus
);

  localparam logic [11:0] C_SPEED   = 12'(SPEED);
  localparam logic [11:0] C_WRAP    = 12'(3 * SPACING - SPEED);
  localparam logic [11:0] C_TW      = 12'(TUBE_WIDTH);
  localparam logic [11:0] C_PASS    = 12'(PASS_X);
  localparam logic [10:0] C_GAP_MIN = 11'(GAP_MIN);

  localparam logic [NUM_TUBES-1:0][X_W-1:0] C_INIT_X = {
    11'(SCREEN_W + 2 * SPACING),
    11'(SCREEN_W + SPACING),
    11'(SCREEN_W)
  };
  localparam logic [NUM_TUBES-1:0][X_W-1:0] C_INIT_GAP = {NUM_TUBES{11'(GAP_MIN + 128)}};

  tube_state_t                   state_q, state_d;
  logic [1:0]                    idx_q, idx_d;
  logic [NUM_TUBES-1:0][X_W-1:0] tube_x_q, tube_x_d;
  logic [NUM_TUBES-1:0][X_W-1:0] gap_y_q, gap_y_d;
  logic                          pass_q, pass_d;
  logic                          running_q, running_d;

  logic [15:0] lfsr_q;
  logic        unused_lfsr_hi;

  logic [11:0] cur_x;
  logic [11:0] new_x;
  logic [10:0] new_gap;
  logic        wrap;
  logic        pass_hit;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (SEED),
    .q    (lfsr_q)
  );

  // Only the low byte feeds the gap offset
  assign unused_lfsr_hi = ^lfsr_q[15:8];

  // Shared move/wrap datapath, operand selected by the sweep index
  always_comb begin
    case (idx_q)
      2'd1:    cur_x = {1'b0, tube_x_q[1]};
      2'd2:    cur_x = {1'b0, tube_x_q[2]};
      default: cur_x = {1'b0, tube_x_q[0]};
    endcase
    wrap = (cur_x < C_SPEED);
    if (wrap) begin
      new_x = cur_x + C_WRAP;
    end else begin
      new_x = cur_x - C_SPEED;
    end
    new_gap  = C_GAP_MIN + {3'b000, lfsr_q[7:0]};
    // A wrapped tube jumps off-screen right, so it can never count as passed
    pass_hit = !wrap && ((cur_x + C_TW) >= C_PASS) && ((new_x + C_TW) < C_PASS);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tube_x_d = tube_x_q;
    gap_y_d  = gap_y_q;
    pass_d   = 1'b0;

    if (bus.start) begin
      // Restart overrides everything, including a sweep in flight
      state_d  = RUN;
      idx_d    = 2'd0;
      tube_x_d = C_INIT_X;
      gap_y_d  = C_INIT_GAP;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        RUN: begin
          if (bus.hold) begin
            state_d = FROZEN;
          end else if (bus.frame_tick) begin
            state_d = SWEEP;
            idx_d   = 2'd0;
          end
        end
        SWEEP: begin
          for (int i = 0; i < NUM_TUBES; i++) begin
            if (idx_q == 2'(i)) begin
              tube_x_d[i] = new_x[10:0];
              if (wrap) begin
                gap_y_d[i] = new_gap;
              end
            end
          end
          pass_d = pass_hit;
          // hold is only honoured once all three tubes are consistent
          if (idx_q == 2'(NUM_TUBES - 1)) begin
            idx_d   = 2'd0;
            state_d = bus.hold ? FROZEN : RUN;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
        FROZEN: begin
          if (!bus.hold) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    running_d = (state_d == RUN) || (state_d == SWEEP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      tube_x_q  <= C_INIT_X;
      gap_y_q   <= C_INIT_GAP;
      pass_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tube_x_q  <= tube_x_d;
      gap_y_q   <= gap_y_d;
      pass_q    <= pass_d;
      running_q <= running_d;
    end
  end

  assign bus.tube_x     = tube_x_q;
  assign bus.gap_y      = gap_y_q;
  assign bus.running    = running_q;
  assign bus.pass_pulse = pass_q;

endmodule
`default_nettype wire
